// File: rtl/biquad_pkg.sv
// biquad_pkg: shared widths, default fractional bits and saturation helpers for the biquad pole stage.
package biquad_pkg;
  localparam int ACC_W = 48;
  localparam int A_W = 30;
  localparam int COEF_W = 18;
  localparam int CNT_W = 5;
  localparam int C_FRAC_DEF = 27;
  localparam int A_FRAC_DEF = 13;
  localparam int NFRAC_DEF = 10;
  function automatic logic sat_fits(input logic signed [ACC_W-1:0] p, input int top);
    logic signed [ACC_W-1:0] s;
    s = p >>> top;
    return (s == '0) || (&s);
  endfunction
  function automatic logic [ACC_W-1:0] sat_slice(input logic signed [ACC_W-1:0] p, input int lo, input int w);
    logic [ACC_W-1:0] mx;
    mx = (ACC_W'(1) << (w - 1)) - ACC_W'(1);
    return sat_fits(p, lo + w - 1) ? p >>> lo : p[ACC_W-1] ? ~mx : mx;
  endfunction
endpackage

// File: rtl/biquad_coeff_chain.sv
// biquad_coeff_chain: coefficient shadow shift chain, active bank, write counter and load-error flag.
module biquad_coeff_chain import biquad_pkg::*; #(
  parameter int    NOUT    = 2,
  parameter string CLKTYPE = "NONE"
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [COEF_W-1:0]                coeff_dat_i,
  input  logic                             coeff_wr_i,
  input  logic                             coeff_update_i,
  output logic [NOUT*NOUT-1:0][COEF_W-1:0] coeff_o,
  output logic [CNT_W-1:0]                 cnt_o,
  output logic                             err_o
);
  localparam int NN = NOUT * NOUT;
  logic [COEF_W-1:0] dat;
  logic wr, upd;
  logic [NN-1:0][COEF_W-1:0] sh_q, sh_d, act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // Coefficients arriving from another clock domain get one retiming stage first.
  if (CLKTYPE != "NONE") begin : g_in_reg
    logic [COEF_W-1:0] dat_q;
    logic wr_q, upd_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_q <= '0;
        wr_q  <= 1'b0;
        upd_q <= 1'b0;
      end else begin
        dat_q <= coeff_dat_i;
        wr_q  <= coeff_wr_i;
        upd_q <= coeff_update_i;
      end
    end
    assign dat = dat_q;
    assign wr  = wr_q;
    assign upd = upd_q;
  end else begin : g_in_pass
    assign dat = coeff_dat_i;
    assign wr  = coeff_wr_i;
    assign upd = coeff_update_i;
  end
  always_comb begin
    sh_d = sh_q;
    sh_d[0] = wr ? dat : sh_q[0];
    for (int e = 1; e < NN; e++) sh_d[e] = wr ? sh_q[e-1] : sh_q[e];
    act_d = upd ? sh_q : act_q;
    cnt_d = upd ? CNT_W'(wr) : (wr && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q | (upd && cnt_q != CNT_W'(NN));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      act_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign coeff_o = act_q;
  assign cnt_o   = cnt_q;
  assign err_o   = err_q;
endmodule

// File: rtl/biquad_pole_iir_mimo.sv
// biquad_pole_iir_mimo: NOUT x NOUT look-ahead pole recurrence with saturated outputs.
// Each output is its registered FIR term plus coupled feedback of all outputs from two clocks back.
module biquad_pole_iir_mimo import biquad_pkg::*; #(
  parameter int    NOUT        = 2,
  parameter int    NBITS       = 24,
  parameter int    NFRAC       = NFRAC_DEF,
  parameter int    C_FRAC_BITS = C_FRAC_DEF,
  parameter int    A_FRAC_BITS = A_FRAC_DEF,
  parameter string CLKTYPE     = "NONE"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COEF_W-1:0]       coeff_dat_i,
  input  logic                    coeff_wr_i,
  input  logic                    coeff_update_i,
  input  logic                    clear_i,
  input  logic [ACC_W*NOUT-1:0]   fir_in,
  output logic [NBITS*NOUT-1:0]   y_out,
  output logic [NOUT-1:0]         ovf_o,
  output logic [CNT_W-1:0]        coeff_cnt_o,
  output logic                    coeff_err_o
);
  logic [NOUT*NOUT-1:0][COEF_W-1:0] coeff;
  logic [NOUT-1:0][ACC_W-1:0] fir_q, fir_d, p_q, p_d;
  logic [NOUT-1:0][A_W-1:0] a_q, a_d;
  logic [NOUT-1:0][NBITS-1:0] y_q, y_d;
  logic [NOUT-1:0] ovf_q, ovf_d;
  logic signed [ACC_W-1:0] sum;
  biquad_coeff_chain #(.NOUT(NOUT), .CLKTYPE(CLKTYPE)) u_chain (
    .clk            (clk),
    .rst_n          (rst_n),
    .coeff_dat_i    (coeff_dat_i),
    .coeff_wr_i     (coeff_wr_i),
    .coeff_update_i (coeff_update_i),
    .coeff_o        (coeff),
    .cnt_o          (coeff_cnt_o),
    .err_o          (coeff_err_o)
  );
  // a_q delays the truncated feedback one more clock so products see P(n-2).
  always_comb begin
    fir_d = clear_i ? '0 : fir_in;
    a_d = '0;
    p_d = '0;
    y_d = '0;
    ovf_d = ovf_q;
    sum = '0;
    for (int j = 0; j < NOUT; j++) a_d[j] = clear_i ? '0 : p_q[j][C_FRAC_BITS-A_FRAC_BITS +: A_W];
    for (int k = 0; k < NOUT; k++) begin
      sum = fir_q[k];
      for (int j = 0; j < NOUT; j++)
        sum = sum + ACC_W'(signed'(coeff[k*NOUT+j])) * ACC_W'(signed'(a_q[j]));
      p_d[k] = clear_i ? '0 : sum;
      y_d[k] = clear_i ? '0 : NBITS'(sat_slice(p_q[k], C_FRAC_BITS - NFRAC, NBITS));
      ovf_d[k] = ovf_q[k] | (!clear_i && !sat_fits(p_q[k], C_FRAC_BITS - NFRAC + NBITS - 1));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_q <= '0;
      a_q   <= '0;
      p_q   <= '0;
      y_q   <= '0;
      ovf_q <= '0;
    end else begin
      fir_q <= fir_d;
      a_q   <= a_d;
      p_q   <= p_d;
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end
  assign y_out = y_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_biquad_pole_iir_mimo.sv
// tb_biquad_pole_iir_mimo: directed checks of reset, impulse, pole decay, coupling, saturation and loading.
module tb_biquad_pole_iir_mimo;
  localparam int NOUT = 2;
  localparam int NBITS = 24;
  localparam logic [47:0] ONE = 48'h0000_0800_0000;
  localparam logic [47:0] BIG = 48'h0100_0000_0000;
  localparam logic [47:0] NEG = 48'hFE00_0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [17:0] coeff_dat = '0;
  logic coeff_wr = 1'b0;
  logic coeff_update = 1'b0;
  logic clear = 1'b0;
  logic [48*NOUT-1:0] fir_in = '0;
  logic [NBITS*NOUT-1:0] y_out;
  logic [NOUT-1:0] ovf;
  logic [4:0] cnt;
  logic err;
  int total = 0;
  int bad = 0;
  int decay [7] = '{1024, 0, 512, 0, 256, 0, 128};
  always #5 clk = ~clk;
  biquad_pole_iir_mimo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .coeff_dat_i    (coeff_dat),
    .coeff_wr_i     (coeff_wr),
    .coeff_update_i (coeff_update),
    .clear_i        (clear),
    .fir_in         (fir_in),
    .y_out          (y_out),
    .ovf_o          (ovf),
    .coeff_cnt_o    (cnt),
    .coeff_err_o    (err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [17:0] v);
    coeff_dat = v;
    coeff_wr = 1'b1;
    tick();
    coeff_wr = 1'b0;
  endtask
  task automatic upd();
    coeff_update = 1'b1;
    tick();
    coeff_update = 1'b0;
  endtask
  task automatic pulse();
    fir_in[47:0] = ONE;
    tick();
    fir_in = '0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_y", 64'(y_out), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_err", 64'(err), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_y", 64'(y_out), 0);
    pulse();
    tick();
    chk("imp_e1", 64'(y_out[23:0]), 0);
    tick();
    chk("imp_y0", 64'(y_out[23:0]), 1024);
    chk("imp_y1", 64'(y_out[47:24]), 0);
    tick();
    chk("imp_e3", 64'(y_out[23:0]), 0);
    wr(18'h0); wr(18'h0); wr(18'h0); wr(18'h2000);
    chk("pole_cnt4", 64'(cnt), 4);
    upd();
    chk("pole_cnt0", 64'(cnt), 0);
    chk("pole_err0", 64'(err), 0);
    pulse();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("pole_y0_e%0d", i + 2), 64'(y_out[23:0]), 64'(decay[i]));
      chk($sformatf("pole_y1_e%0d", i + 2), 64'(y_out[47:24]), 0);
    end
    clear = 1'b1;
    fir_in[47:0] = ONE;
    tick();
    clear = 1'b0;
    fir_in = '0;
    chk("clr_now", 64'(y_out), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("clr_hold%0d", i), 64'(y_out), 0);
    end
    wr(18'h0); wr(18'h4000); wr(18'h0); wr(18'h0);
    upd();
    pulse();
    tick();
    tick();
    chk("xc_y0_e2", 64'(y_out[23:0]), 1024);
    chk("xc_y1_e2", 64'(y_out[47:24]), 0);
    tick();
    tick();
    chk("xc_y0_e4", 64'(y_out[23:0]), 0);
    chk("xc_y1_e4", 64'(y_out[47:24]), 1024);
    tick();
    chk("xc_y1_e5", 64'(y_out[47:24]), 0);
    chk("xc_ovf", 64'(ovf), 0);
    fir_in[47:0] = BIG;
    repeat (3) tick();
    chk("sat_pos", 64'(y_out[23:0]), 64'h7FFFFF);
    chk("sat_ovf0", 64'(ovf[0]), 1);
    fir_in = '0;
    repeat (6) tick();
    chk("sat_drain", 64'(y_out), 0);
    chk("sat_sticky", 64'(ovf), 3);
    fir_in[47:0] = NEG;
    repeat (3) tick();
    chk("sat_neg", 64'(y_out[23:0]), 64'h800000);
    fir_in = '0;
    repeat (6) tick();
    chk("neg_drain", 64'(y_out), 0);
    wr(18'h0); wr(18'h0); wr(18'h0);
    chk("ld_cnt3", 64'(cnt), 3);
    upd();
    chk("ld_err", 64'(err), 1);
    chk("ld_cnt0", 64'(cnt), 0);
    wr(18'h2000);
    chk("ld_cnt1", 64'(cnt), 1);
    coeff_dat = 18'h4000;
    coeff_wr = 1'b1;
    coeff_update = 1'b1;
    tick();
    coeff_wr = 1'b0;
    coeff_update = 1'b0;
    chk("wu_cnt", 64'(cnt), 1);
    chk("wu_err", 64'(err), 1);
    pulse();
    tick();
    tick();
    chk("wu_y0_e2", 64'(y_out[23:0]), 1024);
    tick();
    chk("wu_y0_e3", 64'(y_out[23:0]), 0);
    tick();
    chk("wu_y0_e4", 64'(y_out[23:0]), 512);
    chk("wu_y1_e4", 64'(y_out[47:24]), 0);
    for (int i = 0; i < 35; i++) wr(18'(i));
    chk("cnt_sat", 64'(cnt), 31);
    rst_n = 1'b0;
    #1;
    chk("rst2_cnt", 64'(cnt), 0);
    chk("rst2_err", 64'(err), 0);
    chk("rst2_ovf", 64'(ovf), 0);
    chk("rst2_y", 64'(y_out), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
